// File: rtl/multi_freq_div.sv
// multi_freq_div: multi-channel programmable clock-enable and divided-clock generator
module multi_freq_div #(
    parameter int N_CH    = 4,
    parameter int DIV_W   = 16,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int DEF_DIV = 10,
    parameter int DEF_HI  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_hi,
    output logic [N_CH-1:0]  div_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  cfg_pend
);
    logic [DIV_W-1:0] cnt    [N_CH];
    logic [DIV_W-1:0] act_r  [N_CH];
    logic [DIV_W-1:0] act_h  [N_CH];
    logic [DIV_W-1:0] sh_r   [N_CH];
    logic [DIV_W-1:0] sh_h   [N_CH];
    logic [DIV_W-1:0] cnt_n  [N_CH];
    logic [DIV_W-1:0] act_r_n[N_CH];
    logic [DIV_W-1:0] act_h_n[N_CH];
    logic [DIV_W-1:0] sh_r_n [N_CH];
    logic [DIV_W-1:0] sh_h_n [N_CH];
    logic [N_CH-1:0]  running, wr, wrap, step, load, pend_n, div_n;

    // A channel only advances its count when enabled, running, unsynced and not parked;
    // every other edge is a load point where the shadow ratio becomes active.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr[i]      = cfg_we && cfg_ch == CH_W'(i);
            sh_r_n[i]  = wr[i] ? cfg_div : sh_r[i];
            sh_h_n[i]  = wr[i] ? cfg_hi : sh_h[i];
            wrap[i]    = en[i] && running[i] && !sync && act_r[i] != '0 && cnt[i] == act_r[i] - DIV_W'(1);
            step[i]    = en[i] && running[i] && !sync && act_r[i] != '0 && !wrap[i];
            load[i]    = !step[i];
            act_r_n[i] = load[i] ? sh_r_n[i] : act_r[i];
            act_h_n[i] = load[i] ? sh_h_n[i] : act_h[i];
            cnt_n[i]   = step[i] ? cnt[i] + DIV_W'(1) : '0;
            pend_n[i]  = !load[i] && (wr[i] || cfg_pend[i]);
            div_n[i]   = en[i] && act_r_n[i] != '0 && cnt_n[i] < act_h_n[i];
        end
    end

    // Channel state and registered outputs; reset drops outputs without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running  <= '0;
            div_out  <= '0;
            tick     <= '0;
            cfg_pend <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]   <= '0;
                act_r[i] <= DIV_W'(DEF_DIV);
                act_h[i] <= DIV_W'(DEF_HI);
                sh_r[i]  <= DIV_W'(DEF_DIV);
                sh_h[i]  <= DIV_W'(DEF_HI);
            end
        end else begin
            running  <= en;
            div_out  <= div_n;
            tick     <= wrap;
            cfg_pend <= pend_n;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]   <= cnt_n[i];
                act_r[i] <= act_r_n[i];
                act_h[i] <= act_h_n[i];
                sh_r[i]  <= sh_r_n[i];
                sh_h[i]  <= sh_h_n[i];
            end
        end
    end
endmodule

// File: tb/tb_multi_freq_div.sv
// tb_multi_freq_div: directed and random checks of multi_freq_div against a period/phase model
module tb_multi_freq_div;
    localparam int N = 3;

    logic         clk = 0;
    logic         rst = 1;
    logic [N-1:0] en = '0;
    logic         sync = 0;
    logic         cfg_we = 0;
    logic [1:0]   cfg_ch = '0;
    logic [15:0]  cfg_div = '0;
    logic [15:0]  cfg_hi = '0;
    logic [N-1:0] div_out, tick, cfg_pend;

    int n_chk = 0;
    int n_pass = 0;

    int m_run[N], m_pos[N], m_r[N], m_h[N], m_sr[N], m_sh[N];
    logic [N-1:0] e_div, e_tick, e_pend;

    multi_freq_div #(.N_CH(N), .DIV_W(16), .DEF_DIV(10), .DEF_HI(5)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_hi(cfg_hi), .div_out(div_out), .tick(tick), .cfg_pend(cfg_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_pos[c] = 0;
            m_r[c] = 10; m_h[c] = 5; m_sr[c] = 10; m_sh[c] = 5;
        end
        e_div = '0; e_tick = '0; e_pend = '0;
    endtask

    // Each channel sits at a position inside its period; a period restarts on start,
    // sync, parking or completion, and each restart adopts the latest written ratio.
    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit wr, restart;
            wr = cfg_we && int'(cfg_ch) == c;
            if (wr) begin m_sr[c] = int'(cfg_div); m_sh[c] = int'(cfg_hi); end
            restart = 1;
            e_tick[c] = 0;
            if (!en[c]) begin
                m_run[c] = 0; m_pos[c] = 0;
            end else if (!m_run[c] || sync || m_r[c] == 0) begin
                m_run[c] = 1; m_pos[c] = 0;
            end else if (m_pos[c] == m_r[c] - 1) begin
                m_pos[c] = 0; e_tick[c] = 1;
            end else begin
                m_pos[c]++; restart = 0;
            end
            if (restart) begin
                m_r[c] = m_sr[c]; m_h[c] = m_sh[c]; e_pend[c] = 0;
            end else if (wr) e_pend[c] = 1;
            e_div[c] = en[c] && m_r[c] != 0 && m_pos[c] < m_h[c];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("div_out", 32'(div_out), 32'(e_div));
        check("tick", 32'(tick), 32'(e_tick));
        check("cfg_pend", 32'(cfg_pend), 32'(e_pend));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic write(input int ch, input int r, input int h);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_div = 16'(r); cfg_hi = 16'(h);
        cycle();
        cfg_we = 0;
    endtask

    initial begin
        int first;
        model_reset();
        #3;
        check("rst_div", 32'(div_out), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_pend", 32'(cfg_pend), 0);
        @(negedge clk);
        rst = 0;
        run(2);
        en = 3'b001;
        cycle();
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (tick[0] && first == 0) first = k;
        end
        check("first_tick_edge", 32'(first), 10);
        run(2);
        write(0, 4, 1);
        check("pend_after_write", 32'(cfg_pend[0]), 1);
        run(15);
        en = 3'b011;
        write(1, 5, 0);
        run(12);
        write(1, 10, 12);
        run(22);
        write(1, 1, 1);
        run(6);
        write(1, 0, 1);
        run(6);
        write(1, 3, 1);
        run(8);
        en = 3'b001;
        write(0, 10, 5);
        run(10);
        en = 3'b101;
        write(2, 4, 2);
        run(13);
        sync = 1;
        write(2, 6, 3);
        sync = 0;
        check("sync_pend2", 32'(cfg_pend[2]), 0);
        check("sync_no_tick", 32'(tick), 0);
        run(14);
        en = 3'b100;
        cycle();
        check("dis_div0", 32'(div_out[0]), 0);
        write(0, 7, 2);
        check("dis_pend0", 32'(cfg_pend[0]), 0);
        run(3);
        en = 3'b101;
        run(16);
        write(3, 2, 1);
        check("bad_ch_pend", 32'(cfg_pend), 32'(e_pend));
        run(5);
        #2 rst = 1;
        #1;
        model_reset();
        check("arst_div", 32'(div_out), 0);
        check("arst_tick", 32'(tick), 0);
        check("arst_pend", 32'(cfg_pend), 0);
        #1 rst = 0;
        run(25);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) en = 3'($urandom);
            sync = $urandom_range(0, 29) == 0;
            cfg_we = $urandom_range(0, 7) == 0;
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = 16'($urandom_range(0, 7));
            cfg_hi = 16'($urandom_range(0, 8));
            cycle();
        end
        cfg_we = 0; sync = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
